// File: rtl/branch_pkg.sv
// Shared encodings and widths for the execute-stage branch/set resolver.
package branch_pkg;

    localparam int DATA_W = 16;
    localparam int COND_W = 4;

    typedef enum logic [COND_W-1:0] {
        COND_NONE = 4'd0,
        COND_SEQ  = 4'd1,
        COND_SLT  = 4'd2,
        COND_SLE  = 4'd3,
        COND_SCO  = 4'd4,
        COND_BEQZ = 4'd5,
        COND_BNEZ = 4'd6,
        COND_BLTZ = 4'd7,
        COND_BGEZ = 4'd8
    } cond_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_e;

    // PC-relative target; the carry out of bit 15 is intentionally dropped.
    function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc,
                                                        input logic [DATA_W-1:0] disp);
        return pc + disp;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Decodes the condition opcode against the ALU flags; purely combinational.
module cond_eval
    import branch_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              ofl,
    input  logic              cout,
    input  logic              z,
    output logic              cond_true,
    output logic              is_branch,
    output logic              is_set
);

    logic lt_signed;

    // Signed less-than: sign of the difference corrected by overflow.
    assign lt_signed = alu_out[DATA_W-1] ^ ofl;

    always_comb begin
        cond_true = 1'b0;
        is_branch = 1'b0;
        is_set    = 1'b0;
        case (cond)
            COND_SEQ:  begin is_set = 1'b1;    cond_true = z;                     end
            COND_SLT:  begin is_set = 1'b1;    cond_true = lt_signed;             end
            COND_SLE:  begin is_set = 1'b1;    cond_true = lt_signed | z;         end
            COND_SCO:  begin is_set = 1'b1;    cond_true = cout;                  end
            COND_BEQZ: begin is_branch = 1'b1; cond_true = z;                     end
            COND_BNEZ: begin is_branch = 1'b1; cond_true = !z;                    end
            COND_BLTZ: begin is_branch = 1'b1; cond_true = alu_out[DATA_W-1];     end
            COND_BGEZ: begin is_branch = 1'b1; cond_true = !alu_out[DATA_W-1];    end
            default:   begin cond_true = 1'b0;                                    end
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage back end: set-on-condition results, branch resolution, fetch
// redirect and wrong-path squash, registered toward the memory stage.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              ofl,
    input  logic              cout,
    input  logic              z,
    input  logic [COND_W-1:0] cond,
    input  logic [DATA_W-1:0] pc_plus2,
    input  logic [DATA_W-1:0] imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              taken,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc
);

    localparam int CNT_W = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               taken_q, taken_d;
    logic               redirect_q, redirect_d;
    logic [DATA_W-1:0]  redirect_pc_q, redirect_pc_d;

    logic cond_true, is_branch, is_set;
    logic br_taken, accept, load;

    cond_eval u_cond_eval (
        .cond      (cond),
        .alu_out   (alu_out),
        .ofl       (ofl),
        .cout      (cout),
        .z         (z),
        .cond_true (cond_true),
        .is_branch (is_branch),
        .is_set    (is_set)
    );

    assign br_taken = is_branch & cond_true;
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    // State register (FSM state plus squash counter).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only moves on accepted (discarded) slots.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load && br_taken && (SQUASH_CYCLES > 0)) begin
                        state_d = SQUASH;
                        cnt_d   = CNT_W'(SQUASH_CYCLES);
                    end
                end
                SQUASH: begin
                    if (accept) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: only instructions accepted in IDLE reach the output stage.
    always_comb begin
        load = accept & (state_q == IDLE);
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        taken_d       = taken_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (flush) begin
            out_valid_d = 1'b0;
            taken_d     = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            result_d    = is_set ? {{(DATA_W-1){1'b0}}, cond_true} : alu_out;
            taken_d     = br_taken;
            if (br_taken) begin
                redirect_d    = 1'b1;
                redirect_pc_d = branch_target(pc_plus2, imm);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            taken_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            taken_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            taken_q       <= taken_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign taken       = taken_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table plus hand sequences, output scoreboard,
// and a second instance built with no squash window.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        ofl, cout, z;
    logic [3:0]  cond;
    logic [15:0] alu_out, pc_plus2, imm;
    logic        in_ready, out_valid, taken, redirect;
    logic [15:0] result, redirect_pc;

    logic        in_valid_b, out_ready_b;
    logic        in_ready_b, out_valid_b, taken_b, redirect_b;
    logic [15:0] result_b, redirect_pc_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  cond;
        logic [15:0] alu;
        logic        ofl;
        logic        cout;
        logic        z;
        logic [15:0] exp_res;
        logic        exp_tk;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        tk;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_resolve #(.SQUASH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .ofl(ofl), .cout(cout), .z(z), .cond(cond),
        .pc_plus2(pc_plus2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .taken(taken), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    branch_resolve #(.SQUASH_CYCLES(0)) dut_nosq (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .alu_out(alu_out), .ofl(ofl), .cout(cout), .z(z), .cond(cond),
        .pc_plus2(pc_plus2), .imm(imm), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .result(result_b), .taken(taken_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h want 0x%04h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [15:0] a, input logic o,
                         input logic co, input logic zz, input logic [15:0] pc,
                         input logic [15:0] im);
        cond = c; alu_out = a; ofl = o; cout = co; z = zz; pc_plus2 = pc; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic push(input logic [15:0] r, input logic t);
        exp_t e;
        e.res = r;
        e.tk  = t;
        sb.push_back(e);
    endtask

    // Scoreboard: a transfer happens at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got result 0x%04h taken %b want no output at %0t",
                         result, taken, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check16("sb_result", result, e.res);
                check1("sb_taken", taken, e.tk);
            end
        end
    end

    initial begin
        vecs[0]  = '{4'd0,  16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
        vecs[1]  = '{4'd1,  16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[2]  = '{4'd1,  16'h0005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{4'd2,  16'h8003, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{4'd2,  16'h8003, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
        vecs[5]  = '{4'd3,  16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[6]  = '{4'd3,  16'h0004, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{4'd4,  16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[8]  = '{4'd4,  16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{4'd5,  16'h0007, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0};
        vecs[10] = '{4'd6,  16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[11] = '{4'd7,  16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0};
        vecs[12] = '{4'd8,  16'h8000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0};
        vecs[13] = '{4'd9,  16'hABCD, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0};
        vecs[14] = '{4'd15, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        cond = 4'd0; alu_out = 16'h0; ofl = 1'b0; cout = 1'b0; z = 1'b0;
        pc_plus2 = 16'h0; imm = 16'h0;
        step();
        step();
        rst = 1'b0;
        check1("rst_out_valid", out_valid, 1'b0);
        check16("rst_result", result, 16'h0000);
        check1("rst_taken", taken, 1'b0);
        check1("rst_redirect", redirect, 1'b0);
        check16("rst_redirect_pc", redirect_pc, 16'h0000);
        check1("rst_in_ready", in_ready, 1'b1);

        // Back-to-back table vectors with no taken branches.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cond, vecs[i].alu, vecs[i].ofl, vecs[i].cout, vecs[i].z,
                  16'(i * 7), 16'(i * 3));
            push(vecs[i].exp_res, vecs[i].exp_tk);
            step();
            check1("tbl_out_valid", out_valid, 1'b1);
            check1("tbl_redirect", redirect, 1'b0);
        end
        in_valid = 1'b0;
        step();

        // BEQZ taken, two wrong-path slots dropped, third processed.
        drive(4'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010, 16'hFFFA);
        push(16'h0000, 1'b1);
        step();
        check1("beqz_redirect", redirect, 1'b1);
        check16("beqz_target", redirect_pc, 16'h000A);
        check1("beqz_taken", taken, 1'b1);
        drive(4'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check1("sq1_redirect", redirect, 1'b0);
        check1("sq1_out_valid", out_valid, 1'b0);
        drive(4'd5, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        step();
        check1("sq2_out_valid", out_valid, 1'b0);
        check1("sq2_redirect", redirect, 1'b0);
        drive(4'd0, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        push(16'h3333, 1'b0);
        step();
        check1("after_sq_valid", out_valid, 1'b1);
        check16("after_sq_result", result, 16'h3333);
        in_valid = 1'b0;
        step();

        // Target wrap; an idle cycle inside the squash must not consume a slot.
        drive(4'd6, 16'h0042, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0004);
        push(16'h0042, 1'b1);
        step();
        check1("wrap_redirect", redirect, 1'b1);
        check16("wrap_target", redirect_pc, 16'h0002);
        drive(4'd0, 16'h4444, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        drive(4'd0, 16'h4445, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check1("wrap_sq_valid", out_valid, 1'b0);
        drive(4'd0, 16'h4446, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        push(16'h4446, 1'b0);
        step();
        check16("wrap_after_result", result, 16'h4446);

        // Backpressure: hold for three cycles, then original and new back to back.
        drive(4'd0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        push(16'hAAAA, 1'b0);
        step();
        out_ready = 1'b0;
        drive(4'd0, 16'hBBBB, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("bp_in_ready", in_ready, 1'b0);
            step();
            check16("bp_result_hold", result, 16'hAAAA);
            check1("bp_valid_hold", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        push(16'hBBBB, 1'b0);
        #1;
        check1("bp_release_ready", in_ready, 1'b1);
        step();
        check16("bp_new_result", result, 16'hBBBB);
        in_valid = 1'b0;
        step();

        // Flush with one squash slot left; next instruction must be processed.
        drive(4'd8, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0020);
        push(16'h0001, 1'b1);
        step();
        check16("bgez_target", redirect_pc, 16'h0120);
        drive(4'd0, 16'h5550, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        flush = 1'b1;
        drive(4'd0, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        flush = 1'b0;
        check1("flush_out_valid", out_valid, 1'b0);
        check1("flush_taken", taken, 1'b0);
        check1("flush_redirect", redirect, 1'b0);
        drive(4'd1, 16'h0009, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        push(16'h0001, 1'b0);
        step();
        check1("post_flush_valid", out_valid, 1'b1);
        check16("post_flush_result", result, 16'h0001);

        // Reset beats flush and a same-cycle taken branch.
        drive(4'd0, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        push(16'h7777, 1'b0);
        step();
        rst = 1'b1;
        flush = 1'b1;
        drive(4'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0002);
        step();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check1("rst2_out_valid", out_valid, 1'b0);
        check16("rst2_result", result, 16'h0000);
        check1("rst2_taken", taken, 1'b0);
        check1("rst2_redirect", redirect, 1'b0);
        check16("rst2_redirect_pc", redirect_pc, 16'h0000);
        check1("rst2_in_ready", in_ready, 1'b1);

        // No-squash build: taken branch then ALU op on consecutive cycles.
        in_valid_b = 1'b1;
        cond = 4'd5; alu_out = 16'h0050; z = 1'b1; ofl = 1'b0; cout = 1'b0;
        pc_plus2 = 16'h0020; imm = 16'h0010;
        step();
        check1("nosq_br_valid", out_valid_b, 1'b1);
        check1("nosq_br_taken", taken_b, 1'b1);
        check16("nosq_br_result", result_b, 16'h0050);
        check1("nosq_redirect", redirect_b, 1'b1);
        check16("nosq_target", redirect_pc_b, 16'h0030);
        cond = 4'd0; alu_out = 16'h0060; z = 1'b0;
        step();
        check1("nosq_alu_valid", out_valid_b, 1'b1);
        check16("nosq_alu_result", result_b, 16'h0060);
        check1("nosq_alu_taken", taken_b, 1'b0);
        check1("nosq_redirect_off", redirect_b, 1'b0);
        in_valid_b = 1'b0;

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
